sigma_pipe: RTL and testbench
=============================

Name: sigma_pipe

Overview:
- Parametrised, pipelined SHA-2 sigma engine.
- Computes any of the four SHA-2 sigma functions on one word: Σ0, Σ1 (compression) or σ0, σ1 (message schedule).
- Supports 32-bit (SHA-224/256) and 64-bit (SHA-384/512) word widths.
- Sits between the round controller / message scheduler and the datapath adders; uses a valid/ready handshake with full backpressure and a pass-through tag.

Parameters:
- WORD_W, 32, word width; legal values 32 or 64 only (elaboration error otherwise).
- TAG_W, 4, width of the opaque sideband tag carried with each word; minimum 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept this cycle
- in_op  input  2  function select: 0=Σ0, 1=Σ1, 2=σ0, 3=σ1
- in_data  input  WORD_W  operand x
- in_tag  input  TAG_W  sideband, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WORD_W  sigma result
- out_tag  output  TAG_W  tag of the result
- busy  output  1  any stage holds a valid entry

Behaviour:
- Reset (async assert, sync-safe deassert): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0, busy=0. Pipeline contents are discarded.
- Rotation/shift constants, ROR(a), ROR(b), third term:
  - WORD_W=32:
    - Σ0: 2, 13, ROR 22
    - Σ1: 6, 11, ROR 25
    - σ0: 7, 18, SHR 3
    - σ1: 17, 19, SHR 10
  - WORD_W=64:
    - Σ0: 28, 34, ROR 39
    - Σ1: 14, 18, ROR 41
    - σ0: 1, 8, SHR 7
    - σ1: 19, 61, SHR 6
- Result = term_a ^ term_b ^ term_c. SHR is a logical shift with zero fill. All arithmetic is exactly WORD_W bits with no carries.
- Stage 1 (on accept): registers the three terms t_a, t_b, t_c plus tag and s1_valid.
- Stage 2: registers the XOR of the three terms into out_data/out_tag and sets out_valid = s2_valid.
- Latency: exactly 2 cycles from accept edge to out_valid high when out_ready=1. Throughput: 1 word/clock.
- Transfer occurs when valid && ready on the same rising edge.
- s2_load = s1_valid && (!s2_valid || out_ready).
- s1_load = in_valid && in_ready.
- in_ready = !s1_valid || !s2_valid || out_ready. This is a combinational path from out_ready, which is allowed and documented.
- Stage 2 holds out_data/out_tag stable while out_valid && !out_ready. Data must not change under stall.
- Stage 1 holds when s1_valid && !s2_load.
- Simultaneous s1_load and s2_load: stage 1 takes the new word while stage 2 takes the old stage-1 contents. No bubble.
- Full pipe with out_ready=0: in_ready=0, nothing is accepted, and both entries are held.
- Empty pipe: out_valid=0; out_data keeps its last value (don't-care to consumer).
- in_op is sampled only on accept. Changing it while stalled has no effect on entries already in flight.
- Ordering is strictly FIFO; no reordering or dropping.
- busy = s1_valid | s2_valid.
- Reset asserted mid-operation: all in-flight words are lost, outputs go to their reset values immediately, and no partial result is emitted.

Decomposition:
- Package sha2_pkg holds:
  - op encoding constants SIG_BSIG0/BSIG1/SSIG0/SSIG1
  - the per-width rotation/shift constant tables above
  - a word-width check function
- One sub-module, sigma_terms: purely combinational, (op, x) -> t_a, t_b, t_c, parametrised by WORD_W. It is reused by the message-scheduler expansion.
- The pipeline/handshake logic stays in sigma_pipe.

Test Plan:
- WORD_W=32, out_ready=1, x=0x00000001, ops 0..3 back-to-back with tags 0..3. Required out_data: 0x40080400, 0x04200080, 0x02004000, 0x0000A000, with tags 0..3, on consecutive cycles, each 2 cycles after its accept.
- WORD_W=32, x=0xFFFFFFFF: op1 -> 0xFFFFFFFF (rotate only); op2 -> 0x1FFFFFFF. This checks SHR zero fill versus ROR.
- WORD_W=64: op1, x=0x1 -> 0x0004400000800000; op3, x=0x40 -> 0x0008000000000201.
- Backpressure, out_ready=0, push 3 words (A, B, C) continuously:
  - A and B are accepted; in_ready drops on the 3rd cycle.
  - out_data holds A stable for 5 stall cycles.
  - Then out_ready=1 releases A, B, C in order, one per cycle, with no loss or duplication.
- Random in_valid/out_ready toggling over 1000 words, compared against a software reference model. Check: matching values and tags, in-order delivery, and out_data never changing while out_valid && !out_ready.
- Pulse rst_n low for 1 cycle while both stages are valid and stalled. out_valid and busy must drop asynchronously. After release, in_ready=1, and the next accepted word appears 2 cycles later with no stale output.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-2 constants: sigma op encodings, per-width rotate/shift tables
// and the word-width legality check.
package sha2_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned N_OPS = 4;

  localparam logic [OP_W-1:0] SIG_BSIG0 = 2'd0;
  localparam logic [OP_W-1:0] SIG_BSIG1 = 2'd1;
  localparam logic [OP_W-1:0] SIG_SSIG0 = 2'd2;
  localparam logic [OP_W-1:0] SIG_SSIG1 = 2'd3;

  // Tables are indexed by op: BSIG0, BSIG1, SSIG0, SSIG1
  localparam int unsigned ROT_A_32 [N_OPS] = '{2, 6, 7, 17};
  localparam int unsigned ROT_B_32 [N_OPS] = '{13, 11, 18, 19};
  localparam int unsigned SH_C_32  [N_OPS] = '{22, 25, 3, 10};
  localparam int unsigned ROT_A_64 [N_OPS] = '{28, 14, 1, 19};
  localparam int unsigned ROT_B_64 [N_OPS] = '{34, 18, 8, 61};
  localparam int unsigned SH_C_64  [N_OPS] = '{39, 41, 7, 6};

  function automatic bit sig_word_w_ok(int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

  function automatic int unsigned sig_rot_a(int unsigned w, int unsigned op);
    return (w == 64) ? ROT_A_64[OP_W'(op)] : ROT_A_32[OP_W'(op)];
  endfunction

  function automatic int unsigned sig_rot_b(int unsigned w, int unsigned op);
    return (w == 64) ? ROT_B_64[OP_W'(op)] : ROT_B_32[OP_W'(op)];
  endfunction

  function automatic int unsigned sig_sh_c(int unsigned w, int unsigned op);
    return (w == 64) ? SH_C_64[OP_W'(op)] : SH_C_32[OP_W'(op)];
  endfunction

  // Message-schedule sigmas use a logical shift for the third term
  function automatic bit sig_c_is_shr(int unsigned op);
    return OP_W'(op) >= SIG_SSIG0;
  endfunction

endpackage

// File: rtl/sigma_terms.sv
// Combinational SHA-2 sigma term generator: (op, x) -> three terms to be XORed.
module sigma_terms
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [WORD_W-1:0] i_x,
  output logic [WORD_W-1:0] o_t_a_c,
  output logic [WORD_W-1:0] o_t_b_c,
  output logic [WORD_W-1:0] o_t_c_c
);

  logic [WORD_W-1:0] w_a [N_OPS];
  logic [WORD_W-1:0] w_b [N_OPS];
  logic [WORD_W-1:0] w_c [N_OPS];

  // All four ops are built with constant shifts, then muxed by op
  for (genvar g = 0; g < N_OPS; g++) begin : g_op
    localparam int unsigned RA = sig_rot_a(WORD_W, 32'(g));
    localparam int unsigned RB = sig_rot_b(WORD_W, 32'(g));
    localparam int unsigned RC = sig_sh_c(WORD_W, 32'(g));

    assign w_a[g] = (i_x >> RA) | (i_x << (WORD_W - RA));
    assign w_b[g] = (i_x >> RB) | (i_x << (WORD_W - RB));
    if (sig_c_is_shr(32'(g))) begin : g_shr
      assign w_c[g] = i_x >> RC;
    end else begin : g_ror
      assign w_c[g] = (i_x >> RC) | (i_x << (WORD_W - RC));
    end
  end

  assign o_t_a_c = w_a[i_op];
  assign o_t_b_c = w_b[i_op];
  assign o_t_c_c = w_c[i_op];

endmodule

// File: rtl/sigma_pipe.sv
// Two-stage SHA-2 sigma engine with valid/ready handshake and full backpressure.
module sigma_pipe
  import sha2_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [WORD_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  if (!sig_word_w_ok(WORD_W)) begin : g_bad_word_w
    $error("sigma_pipe: WORD_W must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("sigma_pipe: TAG_W must be at least 1");
  end

  logic [WORD_W-1:0] w_t_a;
  logic [WORD_W-1:0] w_t_b;
  logic [WORD_W-1:0] w_t_c;
  logic              w_s1_load;
  logic              w_s2_load;

  logic              r_s1_valid;
  logic [WORD_W-1:0] r_s1_t_a;
  logic [WORD_W-1:0] r_s1_t_b;
  logic [WORD_W-1:0] r_s1_t_c;
  logic [TAG_W-1:0]  r_s1_tag;
  logic              r_s2_valid;
  logic [WORD_W-1:0] r_out_data;
  logic [TAG_W-1:0]  r_out_tag;

  sigma_terms #(.WORD_W(WORD_W)) u_terms (
    .i_op    (in_op),
    .i_x     (in_data),
    .o_t_a_c (w_t_a),
    .o_t_b_c (w_t_b),
    .o_t_c_c (w_t_c)
  );

  // in_ready depends combinationally on out_ready so a full pipe can still stream
  assign in_ready  = !r_s1_valid || !r_s2_valid || out_ready;
  assign w_s1_load = in_valid && in_ready;
  assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);

  // Stage 1: capture the three terms and tag on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_t_a   <= '0;
      r_s1_t_b   <= '0;
      r_s1_t_c   <= '0;
      r_s1_tag   <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= 1'b1;
      r_s1_t_a   <= w_t_a;
      r_s1_t_b   <= w_t_b;
      r_s1_t_c   <= w_t_c;
      r_s1_tag   <= in_tag;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: fold the terms; data holds whenever no new entry is loaded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_out_data <= r_s1_t_a ^ r_s1_t_b ^ r_s1_t_c;
      r_out_tag  <= r_s1_tag;
    end else if (out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_sigma_pipe.sv
// Directed and randomized checks of sigma_pipe at 32- and 64-bit word widths.
module tb_sigma_pipe;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]  in_op;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_tag, out_tag;

  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_busy;
  logic [1:0]  d_in_op;
  logic [63:0] d_in_data, d_out_data;
  logic [3:0]  d_in_tag, d_out_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sigma_pipe #(.WORD_W(32), .TAG_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .busy(busy)
  );

  sigma_pipe #(.WORD_W(64), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op),
    .in_data(d_in_data), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_tag(d_out_tag), .busy(d_busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ror32(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Independent FIPS 180-4 reference for 32-bit words
  function automatic logic [31:0] ref32(logic [1:0] op, logic [31:0] x);
    case (op)
      2'd0:    return ror32(x, 2)  ^ ror32(x, 13) ^ ror32(x, 22);
      2'd1:    return ror32(x, 6)  ^ ror32(x, 11) ^ ror32(x, 25);
      2'd2:    return ror32(x, 7)  ^ ror32(x, 18) ^ (x >> 3);
      default: return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endcase
  endfunction

  logic [31:0] exp_d [4];
  logic [31:0] q_data[$];
  logic [3:0]  q_tag[$];
  logic [31:0] held_data;
  logic [3:0]  held_tag;
  logic        was_stalled;
  int          sent, got_n, cycles;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_op = '0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    d_in_valid = 1'b0; d_in_op = '0; d_in_data = '0; d_in_tag = '0; d_out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst64_out_valid", 64'(d_out_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    // Four ops back-to-back on x=1
    exp_d[0] = 32'h40080400; exp_d[1] = 32'h04200080;
    exp_d[2] = 32'h02004000; exp_d[3] = 32'h0000A000;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      in_op    = 2'(c);
      in_data  = 32'h1;
      in_tag   = 4'(c);
      #1;
      if (c < 2) begin
        chk("ops_early_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("ops_valid", 64'(out_valid), 64'd1);
        chk("ops_data", 64'(out_data), 64'(exp_d[c-2]));
        chk("ops_tag", 64'(out_tag), 64'(c - 2));
      end
      tick();
    end
    in_valid = 1'b0;

    // Rotate-only vs shift zero-fill on all-ones
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 2);
      in_op    = (c == 0) ? 2'd1 : 2'd2;
      in_data  = 32'hFFFFFFFF;
      in_tag   = 4'(8 + c);
      #1;
      if (c == 2) chk("ones_op1", 64'(out_data), 64'hFFFFFFFF);
      if (c == 3) chk("ones_op2", 64'(out_data), 64'h1FFFFFFF);
      tick();
    end
    in_valid = 1'b0;

    // 64-bit instance
    for (int c = 0; c < 4; c++) begin
      d_in_valid = (c < 2);
      d_in_op    = (c == 0) ? 2'd1 : 2'd3;
      d_in_data  = (c == 0) ? 64'h1 : 64'h40;
      d_in_tag   = 4'(c + 1);
      #1;
      if (c == 2) begin
        chk("w64_op1", d_out_data, 64'h0004400000800000);
        chk("w64_op1_tag", 64'(d_out_tag), 64'd1);
      end
      if (c == 3) begin
        chk("w64_op3", d_out_data, 64'h0008000000000201);
        chk("w64_op3_valid", 64'(d_out_valid), 64'd1);
      end
      tick();
    end
    d_in_valid = 1'b0;
    tick();

    // Backpressure: A, B, C with Sigma0
    out_ready = 1'b0;
    in_op = 2'd0;
    in_valid = 1'b1; in_data = 32'h1; in_tag = 4'd5;
    #1 chk("bp_ready_a", 64'(in_ready), 64'd1);
    tick();
    in_data = 32'h2; in_tag = 4'd6;
    #1 chk("bp_ready_b", 64'(in_ready), 64'd1);
    tick();
    in_data = 32'h4; in_tag = 4'd7;
    for (int s = 0; s < 5; s++) begin
      #1;
      chk("bp_ready_full", 64'(in_ready), 64'd0);
      chk("bp_hold_data", 64'(out_data), 64'h40080400);
      chk("bp_hold_tag", 64'(out_tag), 64'd5);
      chk("bp_busy", 64'(busy), 64'd1);
      if (s < 4) tick();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_b_data", 64'(out_data), 64'h80100800);
    chk("bp_b_tag", 64'(out_tag), 64'd6);
    tick();
    chk("bp_c_data", 64'(out_data), 64'h00201001);
    chk("bp_c_tag", 64'(out_tag), 64'd7);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_idle", 64'(busy), 64'd0);

    // Randomized traffic against the reference model
    sent = 0; got_n = 0; cycles = 0; was_stalled = 1'b0;
    held_data = '0; held_tag = '0;
    while ((got_n < 1000) && (cycles < 20000)) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_op     = 2'($urandom_range(0, 3));
      in_data   = $urandom;
      in_tag    = 4'(sent);
      #1;
      if (was_stalled) begin
        chk("rnd_stall_valid", 64'(out_valid), 64'd1);
        chk("rnd_stall_data", 64'(out_data), 64'(held_data));
        chk("rnd_stall_tag", 64'(out_tag), 64'(held_tag));
      end
      if (in_valid && in_ready) begin
        q_data.push_back(ref32(in_op, in_data));
        q_tag.push_back(in_tag);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q_data.size() == 0) begin
          chk("rnd_unexpected_out", 64'd1, 64'd0);
        end else begin
          chk("rnd_data", 64'(out_data), 64'(q_data.pop_front()));
          chk("rnd_tag", 64'(out_tag), 64'(q_tag.pop_front()));
        end
        got_n++;
      end
      was_stalled = out_valid && !out_ready;
      held_data = out_data;
      held_tag  = out_tag;
      tick();
      cycles++;
    end
    chk("rnd_all_received", 64'(got_n), 64'd1000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    chk("rnd_idle", 64'(busy), 64'd0);

    // Async reset while both stages are full and stalled
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_data = 32'h1; in_tag = 4'd3;
    tick(); tick();
    in_valid = 1'b0;
    #1 chk("mid_full_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 2'd1; in_data = 32'hFFFFFFFF; in_tag = 4'd9;
    #1 chk("post_rst_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    tick();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_data", 64'(out_data), 64'hFFFFFFFF);
    chk("post_rst_tag", 64'(out_tag), 64'd9);
    tick();
    chk("post_rst_drained", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
